// File: rtl/b16_dbg_pkg.sv
// Shared types and constants for the b16 UART debug link.
// Holds the command-byte layout and the FSM state encodings.
package b16_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GETHI,
    ST_GETLO,
    ST_ACCESS,
    ST_TXHI,
    ST_TXLO,
    ST_TXACK
  } dbg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned CMD_REG_HI = 2;
  localparam int unsigned CMD_REG_LO = 0;
  localparam logic [7:0]  ACK_DEFAULT = 8'h06;

  function automatic logic [15:0] dbg_addr(input logic [11:0] base, input logic [2:0] rsel);
    return {base, rsel, 1'b0};
  endfunction

endpackage

// File: rtl/b16_dbg_uart_if.sv
// Debugger register-window bus between the UART link (master) and the b16 core (slave).
// r and w are single-cycle strobes; rdata must be valid combinationally in the cycle r=1.
interface b16_dbg_uart_if;
  logic [15:0] addr;
  logic [15:0] data;
  logic [15:0] rdata;
  logic        r;
  logic [1:0]  w;

  modport master (output addr, output data, output r, output w, input rdata);
  modport slave  (input addr, input data, input r, input w, output rdata);
endinterface

// File: rtl/b16_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, glitch-filtered start detect, mid-bit sampling.
// Good bytes appear as a one-cycle valid pulse; a low stop bit gives a one-cycle ferr pulse.
module b16_uart_rx
  import b16_dbg_pkg::*;
#(
  parameter int unsigned CLKDIV = 434
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rxd_i,
  output logic [7:0] data_o,
  output logic      valid_o,
  output logic      ferr_o,
  output rx_state_e state_o
);

  localparam logic [15:0] DIV_M1  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKDIV / 2) - 1);

  rx_state_e   state_q;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        valid_q, ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // Line back high at mid start bit means the edge was a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == DIV_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_q == DIV_M1) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) valid_q <= 1'b1;
            else         ferr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;
  assign state_o = state_q;

endmodule

// File: rtl/b16_dbg_uart.sv
// UART host link driving the b16 debugger register window: command decode,
// one-cycle register access and the 8N1 response transmitter.
module b16_dbg_uart
  import b16_dbg_pkg::*;
#(
  parameter int unsigned CLKDIV  = 434,
  parameter logic [11:0] DBGADDR = 12'hFFE,
  parameter logic [7:0]  ACK     = ACK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic       busy,
  output dbg_state_e state_o,
  output rx_state_e  rx_state_o,
  b16_dbg_uart_if.master bus
);

  localparam logic [15:0] DIV_M1 = 16'(CLKDIV - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  b16_uart_rx #(.CLKDIV(CLKDIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rxd_i   (rxd),
    .data_o  (rx_data),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr),
    .state_o (rx_state_o)
  );

  dbg_state_e  state_q;
  logic [15:0] addr_q, data_q;
  logic        r_q;
  logic [1:0]  w_q;
  logic [2:0]  reg_q;
  logic        txd_q;
  logic [8:0]  tx_sh_q;
  logic [7:0]  tx_lo_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      r_q      <= 1'b0;
      w_q      <= 2'b00;
      reg_q    <= '0;
      txd_q    <= 1'b1;
      tx_sh_q  <= '1;
      tx_lo_q  <= '0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else begin
      r_q <= 1'b0;
      w_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            reg_q <= rx_data[CMD_REG_HI:CMD_REG_LO];
            if (rx_data[CMD_WR_BIT]) begin
              state_q <= ST_GETHI;
            end else begin
              addr_q  <= dbg_addr(DBGADDR, rx_data[CMD_REG_HI:CMD_REG_LO]);
              r_q     <= 1'b1;
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_GETHI: begin
          if (rx_ferr) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            data_q[15:8] <= rx_data;
            state_q      <= ST_GETLO;
          end
        end
        ST_GETLO: begin
          if (rx_ferr) begin
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            data_q[7:0] <= rx_data;
            addr_q      <= dbg_addr(DBGADDR, reg_q);
            w_q         <= 2'b11;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Strobes are live this cycle; rdata is captured straight into the TX frame.
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          txd_q    <= 1'b0;
          if (w_q == 2'b11) begin
            tx_sh_q <= {1'b1, ACK};
            state_q <= ST_TXACK;
          end else begin
            tx_sh_q <= {1'b1, bus.rdata[15:8]};
            tx_lo_q <= bus.rdata[7:0];
            state_q <= ST_TXHI;
          end
        end
        ST_TXHI, ST_TXLO, ST_TXACK: begin
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q <= '0;
              if (state_q == ST_TXHI) begin
                txd_q   <= 1'b0;
                tx_sh_q <= {1'b1, tx_lo_q};
                state_q <= ST_TXLO;
              end else begin
                txd_q   <= 1'b1;
                state_q <= ST_IDLE;
              end
            end else begin
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.addr = addr_q;
  assign bus.data = data_q;
  assign bus.r    = r_q;
  assign bus.w    = w_q;
  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_b16_dbg_uart.sv
// Bench for b16_dbg_uart: fixed vector table, hand sequences for framing/glitch/
// overlap/reset corners, and random commands checked against a command-level model.
module tb_b16_dbg_uart;
  import b16_dbg_pkg::*;

  localparam int CLKDIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       txd, busy;
  dbg_state_e state;
  rx_state_e  rx_state;

  b16_dbg_uart_if bus();

  b16_dbg_uart #(.CLKDIV(CLKDIV), .DBGADDR(12'hFFE)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .rxd        (rxd),
    .txd        (txd),
    .busy       (busy),
    .state_o    (state),
    .rx_state_o (rx_state),
    .bus        (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] wdata;
    logic [15:0] rd;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    int          exp_nb;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
    int          exp_len;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic        r;
    logic [1:0]  w;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        acc_q[$];
  logic [7:0]  txb_q[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned idle_cyc = 0;
  logic        busy_prev = 1'b0;
  int          tx_stop_bad = 0;
  logic [15:0] model_data = 16'h0000;
  vec_t        tbl[6];

  // bus monitor: logs every strobe cycle and the cycle busy drops
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.r || bus.w != 2'b00)
      acc_q.push_back('{cyc, bus.r, bus.w, bus.addr, bus.data});
    if (busy_prev && !busy) idle_cyc = cyc;
    busy_prev = busy;
  end

  // TX line decoder
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (rst_n && txd == 1'b0) begin
        repeat (CLKDIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKDIV) @(negedge clk);
          rb[i] = txd;
        end
        repeat (CLKDIV) @(negedge clk);
        if (txd !== 1'b1) tx_stop_bad++;
        txb_q.push_back(rb);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rxd = stop;
    repeat (CLKDIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // reference model: what one command should do at the register window and on txd
  function automatic vec_t model(input logic [7:0] cmd, input logic [15:0] wdata, input logic [15:0] rd);
    vec_t v;
    v.cmd      = cmd;
    v.wdata    = wdata;
    v.rd       = rd;
    v.exp_addr = 16'hFFE0 + 16'(cmd[2:0]) * 16'd2;
    if (cmd[7]) begin
      v.exp_data = wdata;
      v.exp_nb   = 1;
      v.exp_b0   = 8'h06;
      v.exp_b1   = 8'h00;
      v.exp_len  = 1 + 10 * CLKDIV;
    end else begin
      v.exp_data = model_data;
      v.exp_nb   = 2;
      v.exp_b0   = rd[15:8];
      v.exp_b1   = rd[7:0];
      v.exp_len  = 1 + 20 * CLKDIV;
    end
    return v;
  endfunction

  // scoreboard for one full command
  task automatic run_vec(input vec_t v, input int gap);
    acc_q.delete();
    txb_q.delete();
    exp_q.delete();
    tx_stop_bad = 0;
    bus.rdata = v.rd;
    send_byte(v.cmd, 1'b1);
    if (v.cmd[7]) begin
      repeat (gap) @(negedge clk);
      send_byte(v.wdata[15:8], 1'b1);
      repeat (gap) @(negedge clk);
      send_byte(v.wdata[7:0], 1'b1);
    end
    wait_idle();
    exp_q.push_back(v.exp_b0);
    if (v.exp_nb == 2) exp_q.push_back(v.exp_b1);
    chk("strobe_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) begin
      chk("addr", 32'(acc_q[0].addr), 32'(v.exp_addr));
      chk("data", 32'(acc_q[0].data), 32'(v.exp_data));
      chk("w", 32'(acc_q[0].w), v.cmd[7] ? 32'd3 : 32'd0);
      chk("r", 32'(acc_q[0].r), v.cmd[7] ? 32'd0 : 32'd1);
      chk("frame_len", idle_cyc - acc_q[0].cyc, 32'(v.exp_len));
    end
    chk("tx_count", 32'(txb_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && txb_q.size() > 0)
      chk("tx_byte", 32'(txb_q.pop_front()), 32'(exp_q.pop_front()));
    chk("tx_stop", 32'(tx_stop_bad), 32'd0);
    chk("state_idle", 32'(state), 32'(ST_IDLE));
    if (v.cmd[7]) model_data = v.wdata;
  endtask

  initial begin
    int n;
    int lows;
    vec_t v;

    tbl[0] = '{8'h85, 16'h1234, 16'h0000, 16'hFFEA, 16'h1234, 1, 8'h06, 8'h00, 81};
    tbl[1] = '{8'h04, 16'h0000, 16'hBEEF, 16'hFFE8, 16'h1234, 2, 8'hBE, 8'hEF, 161};
    tbl[2] = '{8'hFF, 16'hA55A, 16'h0000, 16'hFFEE, 16'hA55A, 1, 8'h06, 8'h00, 81};
    tbl[3] = '{8'h78, 16'h0000, 16'h0001, 16'hFFE0, 16'hA55A, 2, 8'h00, 8'h01, 161};
    tbl[4] = '{8'h80, 16'h0000, 16'h0000, 16'hFFE0, 16'h0000, 1, 8'h06, 8'h00, 81};
    tbl[5] = '{8'h03, 16'h0000, 16'hFFFF, 16'hFFE6, 16'h0000, 2, 8'hFF, 8'hFF, 161};

    bus.rdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_r", 32'(bus.r), 32'd0);
    chk("rst_w", 32'(bus.w), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], 2);

    // framing error on a write command byte, then a normal read
    acc_q.delete();
    send_byte(8'h85, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_no_strobe", 32'(acc_q.size()), 32'd0);
    chk("ferr_state", 32'(state), 32'(ST_IDLE));
    chk("ferr_busy", 32'(busy), 32'd0);
    run_vec(model(8'h03, 16'h0000, 16'hA1B2), 0);

    // short low glitch on rxd
    acc_q.delete();
    txb_q.delete();
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_strobe", 32'(acc_q.size()), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_rx_idle", 32'(rx_state), 32'(RX_IDLE));
    chk("glitch_no_tx", 32'(txb_q.size()), 32'd0);

    // read command arriving during the TXLO of a previous read
    acc_q.delete();
    txb_q.delete();
    tx_stop_bad = 0;
    bus.rdata = 16'hC0DE;
    send_byte(8'h01, 1'b1);
    repeat (70) @(negedge clk);
    send_byte(8'h04, 1'b1);
    wait_idle();
    repeat (200) @(negedge clk);
    chk("overlap_strobes", 32'(acc_q.size()), 32'd1);
    chk("overlap_tx_count", 32'(txb_q.size()), 32'd2);
    if (txb_q.size() == 2) begin
      chk("overlap_b0", 32'(txb_q[0]), 32'h0C0);
      chk("overlap_b1", 32'(txb_q[1]), 32'h0DE);
    end
    chk("overlap_idle", 32'(state), 32'(ST_IDLE));

    // reset during the second response byte
    acc_q.delete();
    bus.rdata = 16'h1357;
    send_byte(8'h02, 1'b1);
    n = 0;
    while (state != ST_TXLO && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reached_txlo", 32'(state), 32'(ST_TXLO));
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_state", 32'(state), 32'(ST_IDLE));
    chk("midrst_addr", 32'(bus.addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd == 1'b0) lows++;
    end
    chk("postrst_txd_quiet", 32'(lows), 32'd0);
    repeat (100) @(negedge clk);
    model_data = 16'h0000;
    run_vec(model(8'h06, 16'h0000, 16'h2468), 0);

    // random commands against the model
    for (int i = 0; i < 16; i++) begin
      v = model(8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom));
      run_vec(v, int'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b16_dbg_uart.md
B16_DBG_UART -- requirements
Module: b16_dbg_uart

Purpose: UART host link that drives the b16 debugger register window (run/step, breakpoint, P/T/R/I, stack push/pop), so a host can control the core without a bus master.

Interface
REQ-001 Parameter CLKDIV, default 434: clk cycles per UART bit, legal range 4..65535.
REQ-002 Parameter DBGADDR, default 12'hFFE: value driven on addr[15:4].
REQ-003 Parameter ACK, default 8'h06: byte returned after every write command.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rxd  input  1  UART receive line, 8N1, LSB first, idle high, asynchronous to clk.
REQ-007 txd  output  1  UART transmit line, 8N1, LSB first, idle high.
REQ-008 addr  output  16  debugger address {DBGADDR, reg[2:0], 1'b0}.
REQ-009 data  output  16  write data to the debugger.
REQ-010 r  output  1  one-cycle debugger read strobe.
REQ-011 w  output  2  one-cycle debugger write strobe; only 2'b00 or 2'b11 is driven.
REQ-012 rdata  input  16  debugger read data, valid combinationally in the cycle r=1.
REQ-013 busy  output  1  high while not in IDLE.

Function
REQ-014 rxd passes through a 2-flop synchronizer; both flops reset to 1.
REQ-015 RX detects start on synchronized 1->0 and waits CLKDIV/2 cycles (integer divide). If the line is high again, the edge is discarded as a glitch; otherwise bits are sampled every CLKDIV cycles.
REQ-016 RX: stop bit sampled 0 = framing error; the byte is dropped and the command FSM returns to IDLE.
REQ-017 RX presents each good byte as a one-cycle valid pulse in the cycle after the stop-bit sample.
REQ-018 Command byte: bit7 = write, bits6:3 ignored, bits2:0 = reg.
REQ-019 FSM states: IDLE, GETHI, GETLO, ACCESS, TXHI, TXLO, TXACK.
REQ-020 IDLE + byte with bit7=1 -> GETHI; IDLE + byte with bit7=0 -> ACCESS.
REQ-021 GETHI + byte -> data[15:8], go to GETLO; GETLO + byte -> data[7:0], go to ACCESS.
REQ-022 ACCESS lasts exactly one cycle: addr valid, w=2'b11 for a write or r=1 for a read. On a read, rdata is captured in the same cycle.
REQ-023 ACCESS -> TXACK after a write; ACCESS -> TXHI after a read.
REQ-024 TXHI sends rdata[15:8], then TXLO sends rdata[7:0], then IDLE. TXACK sends ACK, then IDLE.
REQ-025 Each TX state ends the cycle after the stop bit has been held for CLKDIV cycles; frame = 10*CLKDIV cycles.
REQ-026 RX keeps running during ACCESS and the TX states, but bytes completed there are discarded.
REQ-027 addr and data hold their last value outside ACCESS; r and w are 0 outside ACCESS.
REQ-028 No timeout: a partial write waits indefinitely in GETHI/GETLO.

Reset
REQ-029 Reset values: txd=1, r=0, w=2'b00, addr=16'h0000, data=16'h0000, busy=0, FSM=IDLE, RX idle, all bit and baud counters zero.
REQ-030 Reset asserted mid-frame aborts RX and TX immediately. After release, txd stays high until a new response starts, and RX waits for a fresh falling edge.

Structure
REQ-031 Package b16_dbg_pkg holds: state enum, command bit positions (write bit 7, reg 2:0), ACK default.
REQ-032 Sub-module b16_uart_rx (synchronizer, start detect, bit sampling, framing check) is instantiated once. TX and the FSM are inline in b16_dbg_uart.

Verification (CLKDIV=8, DBGADDR=12'hFFE)
REQ-033 Send 8'h85, 8'h12, 8'h34 -> one cycle with addr=16'hFFEA, data=16'h1234, w=2'b11. Then txd carries 8'h06.
REQ-034 rdata=16'hBEEF, send 8'h04 -> one cycle with r=1 and addr=16'hFFE8. Then txd carries 8'hBE, then 8'hEF, 160 cycles total.
REQ-035 Send 8'h85 with stop bit 0 -> no strobe, FSM in IDLE, and a following valid 8'h03 read is served normally.
REQ-036 Drive a 3-cycle low glitch on rxd -> no byte, no strobe.
REQ-037 Assert reset during the second TX byte -> txd=1 and busy=0 immediately. A following read command completes normally.
REQ-038 Send a read command during TXLO of a previous read -> the command is ignored, with exactly one r pulse in total.
